// File: rtl/cgra_obi_port_arbiter_pkg.sv
// Shared types and default sizing for the CGRA OBI port arbiter.
//   obi_req_t  : req, we, be, addr, wdata  (requester -> bus)
//   obi_resp_t : gnt, rvalid, rdata        (bus -> requester)
package cgra_obi_port_arbiter_pkg;

  localparam int unsigned CGRA_ARB_NREQ            = 4;
  localparam int unsigned CGRA_ARB_MAX_OUTSTANDING = 2;
  localparam int unsigned CGRA_ARB_IDW             = $clog2(CGRA_ARB_NREQ);

  typedef logic [CGRA_ARB_IDW-1:0] cgra_arb_idx_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/cgra_obi_port_arbiter_id_fifo.sv
// Outstanding-ID FIFO: remembers which requester owns each granted
// transaction so in-order rvalids can be routed back.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/data_i : enqueue an ID
//   pop_i/data_o  : dequeue; data_o is the current head
//   full_o, empty_o, count_o : occupancy
// Pointer-wrap storage so that DEPTH = 1 is legal.
module cgra_obi_port_arbiter_id_fifo
  import cgra_obi_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = CGRA_ARB_MAX_OUTSTANDING,
  parameter int unsigned WIDTH = CGRA_ARB_IDW
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef logic [PW-1:0] ptr_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wptr_q, wptr_d;
  ptr_t             rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  function automatic ptr_t wrap_inc(input ptr_t p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_en) wptr_d = wrap_inc(wptr_q);
    if (pop_en)  rptr_d = wrap_inc(rptr_q);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push_en) mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/cgra_obi_port_arbiter.sv
// Round-robin arbiter sharing one OBI master port among NREQ CGRA
// requesters, with in-order response routing.
//   clk_i, rst_ni  : clock, async active-low reset
//   req_i[NREQ]    : requester OBI requests
//   resp_o[NREQ]   : requester OBI responses (rdata broadcast)
//   master_req_o   : forwarded request to the ext_bus master port
//   master_resp_i  : response from the ext_bus master port
//   busy_o         : lock held or transactions outstanding
//   err_o          : sticky, rvalid seen with nothing outstanding
module cgra_obi_port_arbiter
  import cgra_obi_port_arbiter_pkg::*;
#(
  parameter int unsigned NREQ            = CGRA_ARB_NREQ,
  parameter int unsigned MAX_OUTSTANDING = CGRA_ARB_MAX_OUTSTANDING
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  req_i [NREQ],
  output obi_resp_t resp_o [NREQ],
  output obi_req_t  master_req_o,
  input  obi_resp_t master_resp_i,
  output logic      busy_o,
  output logic      err_o
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING+1);

  typedef logic [IDW-1:0] idx_t;

  // Returns {found, index} of the first asserted request at or after ptr.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] reqs,
                                           input idx_t ptr);
    logic        found;
    idx_t        pick;
    int unsigned c;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      c = (32'(ptr) + k) % NREQ;
      if (!found && reqs[idx_t'(c)]) begin
        found = 1'b1;
        pick  = idx_t'(c);
      end
    end
    return {found, pick};
  endfunction

  idx_t          rr_ptr_q, rr_ptr_d;
  logic          lock_q, lock_d;
  idx_t          locked_idx_q, locked_idx_d;
  logic          err_q, err_d;

  logic [NREQ-1:0] req_vec;
  logic            rr_found;
  idx_t            rr_idx;
  idx_t            winner;
  logic            has_winner;
  logic            can_issue;
  logic            hs;
  logic            pop;
  obi_req_t        fwd;

  idx_t            head;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) req_vec[i] = req_i[i].req;
  end

  assign {rr_found, rr_idx} = rr_pick(req_vec, rr_ptr_q);

  // A locked requester keeps the bus even if others are requesting.
  assign winner     = lock_q ? locked_idx_q : rr_idx;
  assign has_winner = lock_q | rr_found;
  assign can_issue  = ~fifo_full;

  always_comb begin
    fwd     = req_i[0];
    fwd.req = 1'b0;
    if (has_winner) begin
      fwd     = req_i[winner];
      fwd.req = req_i[winner].req & can_issue;
    end
  end

  assign master_req_o = fwd;
  assign hs           = fwd.req & master_resp_i.gnt;
  assign pop          = master_resp_i.rvalid & ~fifo_empty;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      resp_o[i].gnt    = hs  && (winner == idx_t'(i));
      resp_o[i].rvalid = pop && (head == idx_t'(i));
      resp_o[i].rdata  = master_resp_i.rdata;
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    locked_idx_d = locked_idx_q;
    err_d        = err_q | (master_resp_i.rvalid & fifo_empty);
    if (hs) begin
      rr_ptr_d = (winner == idx_t'(NREQ-1)) ? '0 : winner + 1'b1;
      lock_d   = 1'b0;
    end else if (fwd.req) begin
      lock_d       = 1'b1;
      locked_idx_d = winner;
    end else if (lock_q && !req_i[locked_idx_q].req) begin
      // Requester abandoned a stalled request; release the bus.
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      locked_idx_q <= locked_idx_d;
      err_q        <= err_d;
    end
  end

  cgra_obi_port_arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .data_i  (winner),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy_o = lock_q | (fifo_count != '0);
  assign err_o  = err_q;

endmodule

// File: tb/tb_cgra_obi_port_arbiter.sv
module tb_cgra_obi_port_arbiter;
  import cgra_obi_port_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int MAXO = 2;

  logic      clk = 1'b0;
  logic      rst_n;
  obi_req_t  req_i [NREQ];
  obi_resp_t resp_o [NREQ];
  obi_req_t  mreq;
  obi_resp_t mresp;
  logic      busy, err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int  m_rr, m_lidx;
  bit  m_lock, m_err;
  int  m_q[$];

  int              e_w;
  bit              e_req;
  logic [NREQ-1:0] e_gnt = '0;
  logic [NREQ-1:0] e_rv;

  logic [NREQ-1:0] o_gnt, o_rv;
  logic            o_req, o_busy, o_err;
  logic [31:0]     o_addr, o_rdata2;

  logic [31:0] base_addr [NREQ];
  int          order [6];

  always #5 clk = ~clk;

  cgra_obi_port_arbiter #(
    .NREQ            (NREQ),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req_i),
    .resp_o        (resp_o),
    .master_req_o  (mreq),
    .master_resp_i (mresp),
    .busy_o        (busy),
    .err_o         (err)
  );

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_lidx = 0; m_lock = 0; m_err = 0;
    m_q.delete();
    e_gnt = '0;
  endtask

  task automatic model_eval();
    bit found;
    found = 0;
    e_w   = 0;
    if (m_lock) begin
      e_w = m_lidx; found = 1;
    end else begin
      for (int k = 0; k < NREQ; k++)
        if (!found && req_i[(m_rr + k) % NREQ].req) begin
          found = 1; e_w = (m_rr + k) % NREQ;
        end
    end
    e_req = found && req_i[e_w].req && (m_q.size() < MAXO);
    e_gnt = (e_req && mresp.gnt) ? onehot(e_w) : '0;
    e_rv  = (mresp.rvalid && m_q.size() > 0) ? onehot(m_q[0]) : '0;
  endtask

  task automatic model_update();
    if (mresp.rvalid) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1;
    end
    if (e_req && mresp.gnt) begin
      m_q.push_back(e_w);
      m_rr   = (e_w + 1) % NREQ;
      m_lock = 0;
    end else if (e_req) begin
      m_lock = 1; m_lidx = e_w;
    end else if (m_lock && !req_i[m_lidx].req) begin
      m_lock = 0;
    end
  endtask

  // Inputs already applied at negedge; check settled outputs, then advance.
  task automatic step();
    logic rd_ok;
    #1;
    model_eval();
    rd_ok = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      o_gnt[i] = resp_o[i].gnt;
      o_rv[i]  = resp_o[i].rvalid;
      if (resp_o[i].rdata !== mresp.rdata) rd_ok = 1'b0;
    end
    o_req    = mreq.req;
    o_addr   = mreq.addr;
    o_busy   = busy;
    o_err    = err;
    o_rdata2 = resp_o[2].rdata;
    chk("master_req", 72'(mreq.req), 72'(e_req));
    if (e_req)
      chk("master_fields", 72'({mreq.we, mreq.be, mreq.addr, mreq.wdata}),
          72'({req_i[e_w].we, req_i[e_w].be, req_i[e_w].addr, req_i[e_w].wdata}));
    chk("gnt_vec", 72'(o_gnt), 72'(e_gnt));
    chk("rvalid_vec", 72'(o_rv), 72'(e_rv));
    chk("rdata_bcast", 72'(rd_ok), 72'(1'b1));
    chk("busy", 72'(busy), 72'(m_lock || m_q.size() != 0));
    chk("err", 72'(err), 72'(m_err));
    @(posedge clk);
    model_update();
  endtask

  task automatic drive(input logic [NREQ-1:0] r, input logic g, input logic rv,
                       input logic [31:0] rd);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_i[i].req   = r[i];
      req_i[i].addr  = base_addr[i];
      req_i[i].wdata = 32'hA000_0000 | 32'(i);
      req_i[i].we    = 1'(i % 2);
      req_i[i].be    = 4'hF;
    end
    mresp.gnt    = g;
    mresp.rvalid = rv;
    mresp.rdata  = rd;
    step();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 72'(busy), 72'(1'b0));
    chk("rst_err", 72'(err), 72'(1'b0));
    model_reset();
    for (int i = 0; i < NREQ; i++) req_i[i] = '0;
    mresp = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    base_addr = '{32'h1000_0000, 32'h1100_0004, 32'h2000_0010, 32'h3300_000C};
    order     = '{0, 1, 3, 0, 1, 3};
    rst_n = 1'b0;
    mresp = '0;
    for (int i = 0; i < NREQ; i++) req_i[i] = '0;
    model_reset();
    #3;
    chk("reset_busy", 72'(busy), 72'(1'b0));
    chk("reset_err", 72'(err), 72'(1'b0));
    chk("reset_mreq", 72'(mreq.req), 72'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester
    drive(4'b0100, 1'b1, 1'b0, 32'h0);
    chk("single_gnt", 72'(o_gnt), 72'(4'b0100));
    chk("single_addr", 72'(o_addr), 72'(32'h2000_0010));
    drive(4'b0000, 1'b1, 1'b1, 32'hDEADBEEF);
    chk("single_rvalid", 72'(o_rv), 72'(4'b0100));
    chk("single_rdata", 72'(o_rdata2), 72'(32'hDEADBEEF));

    // Contention among 0, 1, 3 from a fresh pointer
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(4'b1011, 1'b1, k > 0, 32'h100 + 32'(k));
      chk("contend_gnt", 72'(o_gnt), 72'(onehot(order[k])));
      if (k > 0) chk("contend_rv", 72'(o_rv), 72'(onehot(order[k-1])));
    end
    drive(4'b0000, 1'b0, 1'b1, 32'h200);
    chk("contend_rv_last", 72'(o_rv), 72'(onehot(3)));

    // Stall lock on requester 1 while requester 0 rises
    for (int s = 0; s < 3; s++) begin
      drive((s == 0) ? 4'b0010 : 4'b0011, 1'b0, 1'b0, 32'h0);
      chk("stall_addr", 72'(o_addr), 72'(base_addr[1]));
    end
    drive(4'b0011, 1'b1, 1'b0, 32'h0);
    chk("stall_gnt1", 72'(o_gnt), 72'(4'b0010));
    drive(4'b0001, 1'b1, 1'b1, 32'h11);
    chk("stall_gnt0", 72'(o_gnt), 72'(4'b0001));
    chk("stall_rv1", 72'(o_rv), 72'(4'b0010));
    drive(4'b0000, 1'b0, 1'b1, 32'h22);
    chk("stall_rv0", 72'(o_rv), 72'(4'b0001));

    // Outstanding limit with delayed rvalid
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    chk("limit_second_gnt", 72'(o_gnt), 72'(4'b0001));
    for (int k = 0; k < 4; k++) begin
      drive(4'b0001, 1'b1, 1'b0, 32'h0);
      chk("limit_blocked", 72'(o_req), 72'(1'b0));
    end
    drive(4'b0001, 1'b1, 1'b1, 32'h33);
    chk("limit_full_rv", 72'(o_req), 72'(1'b0));
    chk("limit_rv", 72'(o_rv), 72'(4'b0001));
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    chk("limit_resume", 72'(o_gnt), 72'(4'b0001));
    drive(4'b0000, 1'b0, 1'b1, 32'h44);
    drive(4'b0000, 1'b0, 1'b1, 32'h55);

    // Simultaneous push and pop
    drive(4'b1000, 1'b1, 1'b0, 32'h0);
    chk("sim_gnt3", 72'(o_gnt), 72'(4'b1000));
    drive(4'b0010, 1'b1, 1'b1, 32'h66);
    chk("sim_gnt1", 72'(o_gnt), 72'(4'b0010));
    chk("sim_rv_old", 72'(o_rv), 72'(4'b1000));
    drive(4'b0000, 1'b0, 1'b1, 32'h77);
    chk("sim_busy", 72'(o_busy), 72'(1'b1));
    chk("sim_rv_new", 72'(o_rv), 72'(4'b0010));

    // Spurious rvalid
    drive(4'b0000, 1'b0, 1'b1, 32'h88);
    chk("spur_no_rv", 72'(o_rv), 72'(4'b0000));
    for (int k = 0; k < 3; k++) begin
      drive(4'b0000, 1'b0, 1'b0, 32'h0);
      chk("spur_err_held", 72'(o_err), 72'(1'b1));
    end

    // Asynchronous reset while stalled
    drive(4'b0100, 1'b0, 1'b0, 32'h0);
    drive(4'b0100, 1'b0, 1'b0, 32'h0);
    chk("stall_busy", 72'(o_busy), 72'(1'b1));
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_i[i].req && !e_gnt[i] && $urandom_range(15) != 0)) begin
          req_i[i].req   = 1'($urandom_range(1));
          req_i[i].we    = 1'($urandom_range(1));
          req_i[i].be    = 4'($urandom);
          req_i[i].addr  = 32'($urandom);
          req_i[i].wdata = 32'($urandom);
        end
      end
      mresp.gnt    = ($urandom_range(9) < 7);
      mresp.rvalid = (m_q.size() > 0) ? 1'($urandom_range(1)) : ($urandom_range(31) == 0);
      mresp.rdata  = 32'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
